dmem_arbiter: RTL and testbench

Two-port round-robin arbiter sharing the single-port data memory between the core load/store unit (port 0) and a DMA/debug requester (port 1). It selects one request per cycle, translates the byte address to a word index, drives the memory's write/read enables, and returns the registered read data to the winner one cycle later. It also rejects misaligned or out-of-range accesses and counts contention cycles. It sits between the requesters and data_memory in the top level.

---
 rtl/dmem_arbiter.sv | 120 ++++++++++++
 tb/tb_dmem_arbiter.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter between the core load/store unit (port 0) and a
// DMA/debug requester (port 1) in front of a single-port data memory whose read data
// is registered. Faulted accesses are granted but never reach the memory; the fault
// is reported on the winner's response one cycle later.
module dmem_arbiter #(
    parameter int unsigned DEPTH = 1024
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        p0_req_i,
    input  logic        p0_we_i,
    input  logic [31:0] p0_addr_i,
    input  logic [31:0] p0_wdata_i,
    output logic        p0_gnt_o,
    output logic        p0_rvalid_o,
    output logic [31:0] p0_rdata_o,
    output logic        p0_err_o,

    input  logic        p1_req_i,
    input  logic        p1_we_i,
    input  logic [31:0] p1_addr_i,
    input  logic [31:0] p1_wdata_i,
    output logic        p1_gnt_o,
    output logic        p1_rvalid_o,
    output logic [31:0] p1_rdata_o,
    output logic        p1_err_o,

    output logic [31:0] mem_address_o,
    output logic [31:0] mem_write_data_o,
    output logic        mem_write_enable_o,
    output logic        mem_read_enable_o,
    input  logic [31:0] mem_read_data_i,

    output logic [15:0] conflict_count_o
);

    // Port that wins a tie; flips to the other port after every grant.
    logic        prio_q, prio_d;
    // Response pipeline: winner id, legal read issued, fault, faulted read.
    logic        rsel_q, rsel_d;
    logic        rrd_q, rrd_d;
    logic        rerr_q, rerr_d;
    logic        rflt_rd_q, rflt_rd_d;
    logic [15:0] conflict_count_q, conflict_count_d;

    logic        gnt0, gnt1, any_gnt, win;
    logic        win_we;
    logic [31:0] win_addr, win_wdata, win_word;
    logic        fault;
    logic        legal;

    // Arbitration and winner mux. Port 0 drives the memory bus when idle so it is never X.
    always_comb begin
        gnt0      = rst_ni & p0_req_i & (~p1_req_i | ~prio_q);
        gnt1      = rst_ni & p1_req_i & (~p0_req_i | prio_q);
        any_gnt   = gnt0 | gnt1;
        win       = gnt1;
        win_we    = win ? p1_we_i    : p0_we_i;
        win_addr  = win ? p1_addr_i  : p0_addr_i;
        win_wdata = win ? p1_wdata_i : p0_wdata_i;
        win_word  = {2'b00, win_addr[31:2]};
        fault     = (win_addr[1:0] != 2'b00) | (win_word >= 32'(DEPTH));
        legal     = any_gnt & ~fault;
    end

    // Memory request outputs driven from the winner.
    always_comb begin
        mem_address_o      = win_word;
        mem_write_data_o   = win_wdata;
        mem_write_enable_o = legal & win_we;
        mem_read_enable_o  = legal & ~win_we;
        p0_gnt_o           = gnt0;
        p1_gnt_o           = gnt1;
    end

    // Next-state for priority, response pipeline and saturating contention counter.
    always_comb begin
        prio_d           = any_gnt ? ~win : prio_q;
        rsel_d           = any_gnt ? win : rsel_q;
        rrd_d            = legal & ~win_we;
        rerr_d           = any_gnt & fault;
        rflt_rd_d        = any_gnt & fault & ~win_we;
        conflict_count_d = conflict_count_q;
        if (p0_req_i && p1_req_i && (conflict_count_q != 16'hFFFF)) begin
            conflict_count_d = conflict_count_q + 16'd1;
        end
    end

    // State registers; reset drops any in-flight response.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio_q           <= 1'b0;
            rsel_q           <= 1'b0;
            rrd_q            <= 1'b0;
            rerr_q           <= 1'b0;
            rflt_rd_q        <= 1'b0;
            conflict_count_q <= 16'h0000;
        end else begin
            prio_q           <= prio_d;
            rsel_q           <= rsel_d;
            rrd_q            <= rrd_d;
            rerr_q           <= rerr_d;
            rflt_rd_q        <= rflt_rd_d;
            conflict_count_q <= conflict_count_d;
        end
    end

    // Steer the response to the port that won last cycle; the other port sees zeros.
    always_comb begin
        p0_rvalid_o      = ~rsel_q & (rrd_q | rflt_rd_q);
        p0_err_o         = ~rsel_q & rerr_q;
        p0_rdata_o       = (~rsel_q & rrd_q) ? mem_read_data_i : 32'h0;
        p1_rvalid_o      = rsel_q & (rrd_q | rflt_rd_q);
        p1_err_o         = rsel_q & rerr_q;
        p1_rdata_o       = (rsel_q & rrd_q) ? mem_read_data_i : 32'h0;
        conflict_count_o = conflict_count_q;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model of the arbiter and memory.
module tb_dmem_arbiter;
    localparam int unsigned DEPTH = 1024;

    logic        clk, rst_n;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic        p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
    logic [31:0] p0_rdata, p1_rdata;
    logic [31:0] mem_address, mem_write_data, mem_read_data;
    logic        mem_write_enable, mem_read_enable;
    logic [15:0] conflict_count;

    logic [31:0] mem [0:DEPTH-1];

    int n_checks;
    int n_fail;

    // Reference model state.
    int          exp_prio;
    int          exp_cnt;
    logic [31:0] ref_mem [int unsigned];
    bit          pv[2];
    bit          pe[2];
    logic [31:0] pd[2];
    bit          eg[2];
    int          ewin;
    bit          ewe, ere, efault, ewe_req;
    logic [31:0] eaddr, ewdata;

    dmem_arbiter #(.DEPTH(DEPTH)) dut (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .p0_req_i           (p0_req),
        .p0_we_i            (p0_we),
        .p0_addr_i          (p0_addr),
        .p0_wdata_i         (p0_wdata),
        .p0_gnt_o           (p0_gnt),
        .p0_rvalid_o        (p0_rvalid),
        .p0_rdata_o         (p0_rdata),
        .p0_err_o           (p0_err),
        .p1_req_i           (p1_req),
        .p1_we_i            (p1_we),
        .p1_addr_i          (p1_addr),
        .p1_wdata_i         (p1_wdata),
        .p1_gnt_o           (p1_gnt),
        .p1_rvalid_o        (p1_rvalid),
        .p1_rdata_o         (p1_rdata),
        .p1_err_o           (p1_err),
        .mem_address_o      (mem_address),
        .mem_write_data_o   (mem_write_data),
        .mem_write_enable_o (mem_write_enable),
        .mem_read_enable_o  (mem_read_enable),
        .mem_read_data_i    (mem_read_data),
        .conflict_count_o   (conflict_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for data_memory: registered read port, synchronous write.
    always @(posedge clk) begin
        if (mem_read_enable) mem_read_data <= mem[mem_address[9:0]];
        if (mem_write_enable) mem[mem_address[9:0]] <= mem_write_data;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] ref_rd(input int unsigned w);
        return ref_mem.exists(w) ? ref_mem[w] : 32'h0;
    endfunction

    task automatic model_reset();
        exp_prio = 0;
        exp_cnt  = 0;
        pv = '{0, 0};
        pe = '{0, 0};
        pd = '{32'h0, 32'h0};
    endtask

    task automatic drive(input bit r0, input bit w0, input logic [31:0] a0, input logic [31:0] d0,
                         input bit r1, input bit w1, input logic [31:0] a1,
                         input logic [31:0] d1);
        p0_req = r0; p0_we = w0; p0_addr = a0; p0_wdata = d0;
        p1_req = r1; p1_we = w1; p1_addr = a1; p1_wdata = d1;
    endtask

    // Expected grant and memory strobes for the inputs currently applied.
    task automatic predict();
        logic [31:0] a;
        eg[0]   = p0_req && (!p1_req || exp_prio == 0);
        eg[1]   = p1_req && (!p0_req || exp_prio == 1);
        ewin    = eg[1] ? 1 : 0;
        a       = (ewin == 1) ? p1_addr : p0_addr;
        ewdata  = (ewin == 1) ? p1_wdata : p0_wdata;
        ewe_req = (ewin == 1) ? p1_we : p0_we;
        eaddr   = a / 4;
        efault  = (a % 4 != 0) || (a / 4 >= DEPTH);
        ewe     = (eg[0] || eg[1]) && !efault && ewe_req;
        ere     = (eg[0] || eg[1]) && !efault && !ewe_req;
    endtask

    // Advance one clock and update the model with the transaction just predicted.
    task automatic tick();
        bit any, both;
        any  = eg[0] || eg[1];
        both = p0_req && p1_req;
        @(posedge clk);
        #1;
        pv = '{0, 0};
        pe = '{0, 0};
        pd = '{32'h0, 32'h0};
        if (both && exp_cnt < 65535) exp_cnt++;
        if (any) begin
            exp_prio = 1 - ewin;
            if (efault) begin
                pe[ewin] = 1;
                pv[ewin] = !ewe_req;
            end else if (!ewe_req) begin
                pv[ewin] = 1;
                pd[ewin] = ref_rd(eaddr);
            end else begin
                ref_mem[eaddr] = ewdata;
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1, 0, 32'h14, 0, 1, 1, 32'h18, 32'h5);
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if ({p0_gnt, p1_gnt} !== 2'b00) begin n_fail++;
            $display("FAIL reset_gnt: got %b want 00", {p0_gnt, p1_gnt}); end
        n_checks++; if ({mem_write_enable, mem_read_enable} !== 2'b00) begin n_fail++;
            $display("FAIL reset_mem_en: got %b want 00", {mem_write_enable, mem_read_enable}); end
        n_checks++; if ({p0_rvalid, p0_err, p1_rvalid, p1_err} !== 4'b0000) begin n_fail++;
            $display("FAIL reset_resp: got %b want 0000", {p0_rvalid, p0_err, p1_rvalid, p1_err}); end
        n_checks++; if (conflict_count !== 16'h0) begin n_fail++;
            $display("FAIL reset_cnt: got %h want 0000", conflict_count); end
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_basic_read();
        mem[5] = 32'hDEADBEEF;
        ref_mem[5] = 32'hDEADBEEF;
        drive(1, 0, 32'h14, 0, 0, 0, 0, 0);
        @(negedge clk); predict();
        n_checks++; if ({p0_gnt, p1_gnt} !== 2'b10) begin n_fail++;
            $display("FAIL basic_gnt: got %b want 10", {p0_gnt, p1_gnt}); end
        n_checks++; if ({mem_write_enable, mem_read_enable} !== 2'b01) begin n_fail++;
            $display("FAIL basic_mem_en: got %b want 01", {mem_write_enable, mem_read_enable}); end
        n_checks++; if (mem_address !== 32'd5) begin n_fail++;
            $display("FAIL basic_addr: got %h want 5", mem_address); end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk); predict();
        n_checks++; if ({p0_rvalid, p0_err, p0_rdata} !== {2'b10, 32'hDEADBEEF}) begin n_fail++;
            $display("FAIL basic_resp: got %b %b %h want 1 0 deadbeef", p0_rvalid, p0_err, p0_rdata); end
        n_checks++; if ({p1_rvalid, p1_err, p1_rdata} !== 34'h0) begin n_fail++;
            $display("FAIL basic_p1_quiet: got %b %b %h want 0 0 0", p1_rvalid, p1_err, p1_rdata); end
        tick();
    endtask

    task automatic test_alternate();
        bit rv[2];
        logic [31:0] rdat[2];
        do_reset();
        mem[6] = 32'hCAFEF00D;
        ref_mem[6] = 32'hCAFEF00D;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) drive(1, 0, 32'h14, 0, 1, 0, 32'h18, 0);
            else drive(0, 0, 0, 0, 0, 0, 0, 0);
            @(negedge clk); predict();
            if (i < 4) begin
                n_checks++; if ({p0_gnt, p1_gnt} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin n_fail++;
                    $display("FAIL alt_gnt[%0d]: got %b want %b", i, {p0_gnt, p1_gnt},
                             (i % 2 == 0) ? 2'b10 : 2'b01); end
            end
            if (i > 0) begin
                rv[0] = p0_rvalid; rv[1] = p1_rvalid;
                rdat[0] = p0_rdata; rdat[1] = p1_rdata;
                n_checks++;
                if (rv[(i - 1) % 2] !== 1'b1 || rv[i % 2] !== 1'b0 ||
                    rdat[(i - 1) % 2] !== (((i - 1) % 2 == 0) ? 32'hDEADBEEF : 32'hCAFEF00D)) begin
                    n_fail++;
                    $display("FAIL alt_resp[%0d]: got rvalid %b%b rdata %h want port %0d valid",
                             i, rv[0], rv[1], rdat[(i - 1) % 2], (i - 1) % 2);
                end
            end
            if (i == 4) begin
                n_checks++; if (conflict_count !== 16'd4) begin n_fail++;
                    $display("FAIL alt_cnt: got %0d want 4", conflict_count); end
            end
            tick();
        end
    endtask

    task automatic test_raw();
        drive(0, 0, 0, 0, 1, 1, 32'h40, 32'h12345678);
        @(negedge clk); predict();
        n_checks++; if ({p1_gnt, mem_write_enable, mem_read_enable} !== 3'b110) begin n_fail++;
            $display("FAIL raw_wr_strobe: got %b want 110", {p1_gnt, mem_write_enable, mem_read_enable}); end
        n_checks++; if ({mem_address, mem_write_data} !== {32'd16, 32'h12345678}) begin n_fail++;
            $display("FAIL raw_wr_bus: got %h %h want 10 12345678", mem_address, mem_write_data); end
        tick();
        drive(1, 0, 32'h40, 0, 0, 0, 0, 0);
        @(negedge clk); predict();
        n_checks++; if ({p0_gnt, p1_rvalid, p1_err} !== 3'b100) begin n_fail++;
            $display("FAIL raw_rd_gnt: got %b want 100", {p0_gnt, p1_rvalid, p1_err}); end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk); predict();
        n_checks++; if ({p0_rvalid, p0_rdata} !== {1'b1, 32'h12345678}) begin n_fail++;
            $display("FAIL raw_rd_data: got %b %h want 1 12345678", p0_rvalid, p0_rdata); end
        tick();
    endtask

    task automatic test_fault();
        drive(1, 0, 32'h1002, 0, 0, 0, 0, 0);
        @(negedge clk); predict();
        n_checks++; if ({p0_gnt, mem_write_enable, mem_read_enable} !== 3'b100) begin n_fail++;
            $display("FAIL fault_rd_gnt: got %b want 100", {p0_gnt, mem_write_enable, mem_read_enable}); end
        tick();
        drive(0, 0, 0, 0, 1, 1, 32'h1000, 32'hA5A5A5A5);
        @(negedge clk); predict();
        n_checks++; if ({p1_gnt, mem_write_enable, mem_read_enable} !== 3'b100) begin n_fail++;
            $display("FAIL fault_wr_gnt: got %b want 100", {p1_gnt, mem_write_enable, mem_read_enable}); end
        n_checks++; if ({p0_rvalid, p0_err, p0_rdata} !== {2'b11, 32'h0}) begin n_fail++;
            $display("FAIL fault_rd_resp: got %b %b %h want 1 1 0", p0_rvalid, p0_err, p0_rdata); end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk); predict();
        n_checks++; if ({p1_rvalid, p1_err, p1_rdata, p0_rvalid, p0_err} !== {2'b01, 32'h0, 2'b00})
        begin n_fail++;
            $display("FAIL fault_wr_resp: got p1 %b %b %h p0 %b %b want p1 0 1 0 p0 0 0",
                     p1_rvalid, p1_err, p1_rdata, p0_rvalid, p0_err); end
        tick();
    endtask

    task automatic test_random(input int n);
        bit hr[2];
        bit rw[2];
        logic [31:0] ra[2];
        logic [31:0] rd[2];
        hr = '{0, 0}; rw = '{0, 0};
        ra = '{32'h0, 32'h0}; rd = '{32'h0, 32'h0};
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 2; k++) begin
                if (!hr[k] && $urandom_range(0, 9) < 7) begin
                    hr[k] = 1;
                    rw[k] = bit'($urandom_range(0, 1));
                    rd[k] = $urandom;
                    case ($urandom_range(0, 9))
                        0: ra[k] = $urandom_range(0, 15) * 4 + $urandom_range(1, 3);
                        1: ra[k] = (DEPTH + $urandom_range(0, 255)) * 4;
                        2: ra[k] = (DEPTH - 1) * 4;
                        default: ra[k] = $urandom_range(0, 15) * 4;
                    endcase
                end
            end
            drive(hr[0], rw[0], ra[0], rd[0], hr[1], rw[1], ra[1], rd[1]);
            @(negedge clk); predict();
            n_checks++; if ({p0_gnt, p1_gnt} !== {eg[0], eg[1]}) begin n_fail++;
                $display("FAIL rand_gnt[%0d]: got %b%b want %b%b", i, p0_gnt, p1_gnt, eg[0], eg[1]); end
            n_checks++; if ({mem_write_enable, mem_read_enable} !== {ewe, ere}) begin n_fail++;
                $display("FAIL rand_mem_en[%0d]: got %b%b want %b%b", i, mem_write_enable,
                         mem_read_enable, ewe, ere); end
            if (ewe || ere) begin
                n_checks++; if (mem_address !== eaddr) begin n_fail++;
                    $display("FAIL rand_addr[%0d]: got %h want %h", i, mem_address, eaddr); end
            end
            if (ewe) begin
                n_checks++; if (mem_write_data !== ewdata) begin n_fail++;
                    $display("FAIL rand_wdata[%0d]: got %h want %h", i, mem_write_data, ewdata); end
            end
            n_checks++; if ({p0_rvalid, p0_err, p0_rdata} !== {pv[0], pe[0], pd[0]}) begin n_fail++;
                $display("FAIL rand_p0_resp[%0d]: got %b %b %h want %b %b %h", i, p0_rvalid,
                         p0_err, p0_rdata, pv[0], pe[0], pd[0]); end
            n_checks++; if ({p1_rvalid, p1_err, p1_rdata} !== {pv[1], pe[1], pd[1]}) begin n_fail++;
                $display("FAIL rand_p1_resp[%0d]: got %b %b %h want %b %b %h", i, p1_rvalid,
                         p1_err, p1_rdata, pv[1], pe[1], pd[1]); end
            n_checks++; if (conflict_count !== 16'(exp_cnt)) begin n_fail++;
                $display("FAIL rand_cnt[%0d]: got %0d want %0d", i, conflict_count, exp_cnt); end
            tick();
            for (int k = 0; k < 2; k++) if (eg[k]) hr[k] = 0;
        end
    endtask

    task automatic test_reset_inflight();
        do_reset();
        drive(1, 0, 32'h14, 0, 1, 0, 32'h18, 0);
        @(negedge clk); predict();
        n_checks++; if ({p0_gnt, p1_gnt} !== 2'b10) begin n_fail++;
            $display("FAIL rst_fly_gnt: got %b want 10", {p0_gnt, p1_gnt}); end
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++; if ({p0_rvalid, p1_rvalid, p0_gnt, p1_gnt} !== 4'b0000) begin n_fail++;
            $display("FAIL rst_fly_drop: got %b want 0000", {p0_rvalid, p1_rvalid, p0_gnt, p1_gnt}); end
        n_checks++; if (conflict_count !== 16'h0) begin n_fail++;
            $display("FAIL rst_fly_cnt: got %0d want 0", conflict_count); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        @(negedge clk); predict();
        n_checks++; if ({p0_gnt, p1_gnt, p0_rvalid, p1_rvalid} !== 4'b1000) begin n_fail++;
            $display("FAIL rst_fly_after: got %b want 1000", {p0_gnt, p1_gnt, p0_rvalid, p1_rvalid}); end
        n_checks++; if (conflict_count !== 16'h0) begin n_fail++;
            $display("FAIL rst_fly_cnt_after: got %0d want 0", conflict_count); end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk); predict();
        n_checks++; if ({p0_rvalid, p0_rdata, p1_rvalid} !== {pv[0], pd[0], pv[1]}) begin n_fail++;
            $display("FAIL rst_fly_resp: got %b %h %b want %b %h %b", p0_rvalid, p0_rdata,
                     p1_rvalid, pv[0], pd[0], pv[1]); end
        tick();
    endtask

    task automatic test_saturate();
        do_reset();
        drive(1, 0, 32'h0, 0, 1, 0, 32'h4, 0);
        repeat (65534) @(posedge clk);
        #1;
        n_checks++; if (conflict_count !== 16'd65534) begin n_fail++;
            $display("FAIL sat_before: got %0d want 65534", conflict_count); end
        repeat (70000 - 65534) @(posedge clk);
        #1;
        n_checks++; if (conflict_count !== 16'hFFFF) begin n_fail++;
            $display("FAIL sat_reached: got %h want ffff", conflict_count); end
        repeat (10) @(posedge clk);
        #1;
        n_checks++; if (conflict_count !== 16'hFFFF) begin n_fail++;
            $display("FAIL sat_hold: got %h want ffff", conflict_count); end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        mem_read_data = 32'h0;
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'h0;
        model_reset();
        eg = '{0, 0};
        test_reset();
        test_basic_read();
        test_alternate();
        test_raw();
        test_fault();
        test_random(400);
        test_reset_inflight();
        test_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
